soc_system_cpu_0_cpu_ocimem_arbiter: RTL

SOC_SYSTEM_CPU_0_CPU_OCIMEM_ARBITER -- requirements
Module: soc_system_cpu_0_cpu_ocimem_arbiter

---
 rtl/soc_system_cpu_0_cpu_ocimem_arbiter_if.sv | 29 ++
 rtl/soc_system_cpu_0_cpu_ocimem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/soc_system_cpu_0_cpu_ocimem_arbiter_if.sv
// Bus bundle for the OCI memory arbiter.
// Avalon slave side: avs_address/read/write/writedata/byteenable in, avs_readdata/waitrequest out.
// RAM side: ram_addr/wdata/be/en/we out, ram_rdata in.
// 'slave' is the arbiter's view; 'master' is the view of whoever drives Avalon and models the RAM.
interface soc_system_cpu_0_cpu_ocimem_arbiter_if;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_rdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, ram_rdata,
    output avs_readdata, avs_waitrequest, ram_addr, ram_wdata, ram_be, ram_en, ram_we
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, ram_rdata,
    input  avs_readdata, avs_waitrequest, ram_addr, ram_wdata, ram_be, ram_en, ram_we
  );
endinterface

// File: rtl/soc_system_cpu_0_cpu_ocimem_arbiter.sv
// Arbitrates a single-port 256x32 RAM between an Avalon slave and the JTAG debug front end.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   jdo                            debug data word (addr [17:10], wdata [34:3], read-on-load [35])
//   take_action_ocimem_a/_b,
//   take_no_action_ocimem_a        JTAG load-address / write / read pulses
//   MonDReg, monitor_ready         last JTAG read data and its update pulse
//   ocimem_overrun                 sticky: a JTAG request was dropped
//   bus                            Avalon + RAM signals (slave modport)
module soc_system_cpu_0_cpu_ocimem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        ocimem_overrun,
  soc_system_cpu_0_cpu_ocimem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StCap, StDone} state_e;

  localparam logic OwnAvs  = 1'b0;
  localparam logic OwnJtag = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, last_grant_q;
  logic [7:0]  jaddr_q, jaddr_d;
  logic        slot_valid_q, slot_wr_q;
  logic [7:0]  slot_addr_q;
  logic [31:0] slot_wdata_q;
  logic        ram_en_q, ram_we_q;
  logic [7:0]  ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [3:0]  ram_be_q;
  logic [31:0] avs_readdata_q, mon_q;
  logic        monitor_ready_q, overrun_q;

  logic        avs_req, grant_avs, grant_jtag, slot_free;
  logic        enq, enq_wr, overrun_set;
  logic [7:0]  enq_addr;
  logic [31:0] enq_wdata;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Grant and next state. Ties go to whoever was not granted last.
  always_comb begin
    avs_req    = bus.avs_read | bus.avs_write;
    grant_avs  = 1'b0;
    grant_jtag = 1'b0;
    state_d    = state_q;
    if (state_q == StIdle) begin
      if (avs_req && slot_valid_q) begin
        if (last_grant_q == OwnJtag) grant_avs = 1'b1;
        else                         grant_jtag = 1'b1;
      end else if (avs_req) begin
        grant_avs = 1'b1;
      end else if (slot_valid_q) begin
        grant_jtag = 1'b1;
      end
    end
    unique case (state_q)
      StIdle: if (grant_avs || grant_jtag) state_d = StAcc;
      StAcc: begin
        if (!ram_we_q)              state_d = StCap;
        else if (owner_q == OwnAvs) state_d = StDone;
        else                        state_d = StIdle;
      end
      StCap:   state_d = (owner_q == OwnAvs) ? StDone : StIdle;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // JTAG front end: one pulse honoured per cycle, others and slot collisions flag overrun.
  always_comb begin
    slot_free   = !slot_valid_q || grant_jtag;
    enq         = 1'b0;
    enq_wr      = 1'b0;
    enq_addr    = jaddr_q;
    enq_wdata   = jdo[34:3];
    jaddr_d     = jaddr_q;
    overrun_set = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                  (take_action_ocimem_b & take_no_action_ocimem_a);
    if (take_action_ocimem_a) begin
      jaddr_d = jdo[17:10];
      if (jdo[35]) begin
        if (slot_free) begin
          enq      = 1'b1;
          enq_addr = jdo[17:10];
          jaddr_d  = jdo[17:10] + 8'd1;
        end else begin
          overrun_set = 1'b1;
        end
      end
    end else if (take_action_ocimem_b || take_no_action_ocimem_a) begin
      if (slot_free) begin
        enq     = 1'b1;
        enq_wr  = take_action_ocimem_b;
        jaddr_d = jaddr_q + 8'd1;
      end else begin
        overrun_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      owner_q         <= OwnJtag;
      last_grant_q    <= OwnJtag;
      jaddr_q         <= 8'd0;
      slot_valid_q    <= 1'b0;
      slot_wr_q       <= 1'b0;
      slot_addr_q     <= 8'd0;
      slot_wdata_q    <= 32'd0;
      ram_en_q        <= 1'b0;
      ram_we_q        <= 1'b0;
      ram_addr_q      <= 8'd0;
      ram_wdata_q     <= 32'd0;
      ram_be_q        <= 4'd0;
      avs_readdata_q  <= 32'd0;
      mon_q           <= 32'd0;
      monitor_ready_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      jaddr_q  <= jaddr_d;
      ram_en_q <= grant_avs | grant_jtag;
      if (overrun_set) overrun_q <= 1'b1;

      if (enq) begin
        slot_valid_q <= 1'b1;
        slot_wr_q    <= enq_wr;
        slot_addr_q  <= enq_addr;
        slot_wdata_q <= enq_wdata;
      end else if (grant_jtag) begin
        slot_valid_q <= 1'b0;
      end

      // The Avalon request is captured here; the master keeps it stable until completion.
      if (grant_avs) begin
        ram_addr_q   <= bus.avs_address;
        ram_wdata_q  <= bus.avs_writedata;
        ram_be_q     <= bus.avs_byteenable;
        ram_we_q     <= bus.avs_write;
        owner_q      <= OwnAvs;
        last_grant_q <= OwnAvs;
      end else if (grant_jtag) begin
        ram_addr_q   <= slot_addr_q;
        ram_wdata_q  <= slot_wdata_q;
        ram_be_q     <= 4'hF;
        ram_we_q     <= slot_wr_q;
        owner_q      <= OwnJtag;
        last_grant_q <= OwnJtag;
      end

      monitor_ready_q <= 1'b0;
      if (state_q == StCap) begin
        if (owner_q == OwnAvs) begin
          avs_readdata_q <= bus.ram_rdata;
        end else begin
          mon_q           <= bus.ram_rdata;
          monitor_ready_q <= 1'b1;
        end
      end
    end
  end

  assign bus.avs_waitrequest = (state_q != StDone);
  assign bus.avs_readdata    = avs_readdata_q;
  assign bus.ram_en          = ram_en_q;
  assign bus.ram_we          = ram_we_q;
  assign bus.ram_addr        = ram_addr_q;
  assign bus.ram_wdata       = ram_wdata_q;
  assign bus.ram_be          = ram_be_q;
  assign MonDReg             = mon_q;
  assign monitor_ready       = monitor_ready_q;
  assign ocimem_overrun      = overrun_q;

endmodule
